// File: rtl/ec_coe_rd_ctrl.sv
// Coefficient read sequencer for CABAC residual coding: walks Y/U/V 4x4 blocks in z-scan
// order, reads them from the coefficient buffer and hands them out through a 2-entry FIFO.
`ifndef COEFF_WIDTH
`define COEFF_WIDTH 16
`endif

module ec_coe_rd_ctrl #(
  parameter int unsigned COEFF_WIDTH = `COEFF_WIDTH,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [1:0]                cu_size_i,
  input  logic                      cbf_y_i,
  input  logic                      cbf_u_i,
  input  logic                      cbf_v_i,
  output logic                      coe_rd_ena_o,
  output logic [8:0]                coe_rd_addr_o,
  output logic [1:0]                coe_rd_sel_o,
  input  logic [16*COEFF_WIDTH-1:0] coe_rd_dat_i,
  output logic                      blk_val_o,
  input  logic                      blk_rdy_i,
  output logic [16*COEFF_WIDTH-1:0] blk_dat_o,
  output logic [1:0]                blk_sel_o,
  output logic [7:0]                blk_idx_o,
  output logic                      blk_last_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int unsigned DW   = 16 * COEFF_WIDTH;
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned UW   = CntW + 1;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRdY   = 3'd1;
  localparam logic [2:0] StRdU   = 3'd2;
  localparam logic [2:0] StRdV   = 3'd3;
  localparam logic [2:0] StDrain = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [1:0]      size_q;
  logic            cbf_y_q, cbf_u_q, cbf_v_q;
  logic [7:0]      idx_q;

  logic            inflight_q;
  logic [1:0]      dly_sel_q;
  logic [7:0]      dly_idx_q;
  logic            dly_last_q;

  logic [DW-1:0]   mem_dat_q  [FIFO_DEPTH];
  logic [1:0]      mem_sel_q  [FIFO_DEPTH];
  logic [7:0]      mem_idx_q  [FIFO_DEPTH];
  logic            mem_last_q [FIFO_DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q, count_d;

  logic [7:0]      luma_last, chroma_last, cur_last;
  logic            in_rd, issue, terminal, push, pop;
  logic [1:0]      rd_sel;
  logic [2:0]      next_comp;
  logic [UW-1:0]   used_credit;

  always_comb begin
    case (size_q)
      2'd0:    begin luma_last = 8'd3;   chroma_last = 8'd0;  end
      2'd1:    begin luma_last = 8'd15;  chroma_last = 8'd3;  end
      2'd2:    begin luma_last = 8'd63;  chroma_last = 8'd15; end
      default: begin luma_last = 8'd255; chroma_last = 8'd63; end
    endcase
  end

  always_comb begin
    in_rd     = 1'b0;
    rd_sel    = 2'd0;
    cur_last  = chroma_last;
    next_comp = StDrain;
    case (state_q)
      StRdY: begin
        in_rd     = 1'b1;
        rd_sel    = 2'd2;
        cur_last  = luma_last;
        next_comp = cbf_u_q ? StRdU : (cbf_v_q ? StRdV : StDrain);
      end
      StRdU: begin
        in_rd     = 1'b1;
        rd_sel    = 2'd1;
        next_comp = cbf_v_q ? StRdV : StDrain;
      end
      StRdV: begin
        in_rd     = 1'b1;
        rd_sel    = 2'd0;
      end
      default: ;
    endcase
  end

  assign blk_val_o = (count_q != '0);
  assign pop       = blk_val_o & blk_rdy_i;
  assign push      = inflight_q;

  // A pop this cycle frees a slot in time for the data returned next cycle, which is
  // what keeps a ready consumer fed at one block per cycle.
  assign used_credit = UW'(count_q) + UW'(inflight_q) - UW'(pop);
  assign issue       = in_rd && (used_credit < UW'(FIFO_DEPTH));
  assign terminal    = issue && (idx_q == cur_last);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          if (cbf_y_i)      state_d = StRdY;
          else if (cbf_u_i) state_d = StRdU;
          else if (cbf_v_i) state_d = StRdV;
          else              state_d = StDone;
        end
      end
      StRdY, StRdU, StRdV: if (terminal) state_d = next_comp;
      StDrain:             if (pop && blk_last_o) state_d = StDone;
      StDone:              state_d = StIdle;
      default:             state_d = StIdle;
    endcase
  end

  assign count_d = count_q + CntW'(push) - CntW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      size_q     <= 2'd0;
      cbf_y_q    <= 1'b0;
      cbf_u_q    <= 1'b0;
      cbf_v_q    <= 1'b0;
      idx_q      <= 8'd0;
      inflight_q <= 1'b0;
      dly_sel_q  <= 2'd0;
      dly_idx_q  <= 8'd0;
      dly_last_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_dat_q[i]  <= '0;
        mem_sel_q[i]  <= 2'd0;
        mem_idx_q[i]  <= 8'd0;
        mem_last_q[i] <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && start_i) begin
        size_q  <= cu_size_i;
        cbf_y_q <= cbf_y_i;
        cbf_u_q <= cbf_u_i;
        cbf_v_q <= cbf_v_i;
      end
      if (terminal)   idx_q <= 8'd0;
      else if (issue) idx_q <= idx_q + 8'd1;

      inflight_q <= issue;
      if (issue) begin
        dly_sel_q  <= rd_sel;
        dly_idx_q  <= idx_q;
        dly_last_q <= terminal && (next_comp == StDrain);
      end

      if (push) begin
        mem_dat_q[wptr_q]  <= coe_rd_dat_i;
        mem_sel_q[wptr_q]  <= dly_sel_q;
        mem_idx_q[wptr_q]  <= dly_idx_q;
        mem_last_q[wptr_q] <= dly_last_q;
        wptr_q             <= wptr_q + PtrW'(1);
      end
      if (pop) rptr_q <= rptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  assign coe_rd_ena_o  = issue;
  assign coe_rd_addr_o = {1'b0, idx_q};
  assign coe_rd_sel_o  = rd_sel;

  assign blk_dat_o  = mem_dat_q[rptr_q];
  assign blk_sel_o  = mem_sel_q[rptr_q];
  assign blk_idx_o  = mem_idx_q[rptr_q];
  assign blk_last_o = mem_last_q[rptr_q];

  assign busy_o = (state_q != StIdle);
  assign done_o = (state_q == StDone);

endmodule

// File: tb/tb_ec_coe_rd_ctrl.sv
// Scoreboard bench for ec_coe_rd_ctrl: a coefficient memory model answers reads and the
// expected block stream of each CU is queued at start and compared as blocks are accepted.
module tb_ec_coe_rd_ctrl;

  localparam int unsigned CW = 16;
  localparam int unsigned DW = 16 * CW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic [1:0]    cu_size_i;
  logic          cbf_y_i, cbf_u_i, cbf_v_i;
  logic          coe_rd_ena_o;
  logic [8:0]    coe_rd_addr_o;
  logic [1:0]    coe_rd_sel_o;
  logic [DW-1:0] coe_rd_dat_i = '0;
  logic          blk_val_o;
  logic          blk_rdy_i;
  logic [DW-1:0] blk_dat_o;
  logic [1:0]    blk_sel_o;
  logic [7:0]    blk_idx_o;
  logic          blk_last_o;
  logic          busy_o;
  logic          done_o;

  ec_coe_rd_ctrl #(.COEFF_WIDTH(CW), .FIFO_DEPTH(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .cu_size_i     (cu_size_i),
    .cbf_y_i       (cbf_y_i),
    .cbf_u_i       (cbf_u_i),
    .cbf_v_i       (cbf_v_i),
    .coe_rd_ena_o  (coe_rd_ena_o),
    .coe_rd_addr_o (coe_rd_addr_o),
    .coe_rd_sel_o  (coe_rd_sel_o),
    .coe_rd_dat_i  (coe_rd_dat_i),
    .blk_val_o     (blk_val_o),
    .blk_rdy_i     (blk_rdy_i),
    .blk_dat_o     (blk_dat_o),
    .blk_sel_o     (blk_sel_o),
    .blk_idx_o     (blk_idx_o),
    .blk_last_o    (blk_last_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    sel;
    logic [7:0]    idx;
    logic          last;
    logic [DW-1:0] dat;
  } blk_t;

  blk_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   gen      = 0;
  int   cyc      = 0;

  // Monitor-owned statistics; the stimulus side works with deltas against saved bases.
  int   rd_cnt = 0, blk_cnt = 0, val_cnt = 0, done_cnt = 0, outst = 0;
  int   val_rise_cyc = -1, last_acc_cyc = -1, done_cyc = -1;
  logic prev_val = 1'b0, prev_stall = 1'b0;
  blk_t held;

  int   rd_base, blk_base, val_base, done_base, exp_reads, start_cyc;

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_dat(input logic [1:0] s, input logic [7:0] i, input int g);
    logic [DW-1:0] d;
    for (int k = 0; k < 16; k++) d[k*16 +: 16] = 16'(g * 4099 + int'(s) * 1021 + int'(i) * 37 + k * 11 + 1);
    return d;
  endfunction

  always @(posedge clk) cyc++;

  // Coefficient memory: data valid exactly one cycle after a read, junk otherwise.
  always @(posedge clk)
    coe_rd_dat_i <= coe_rd_ena_o ? mk_dat(coe_rd_sel_o, coe_rd_addr_o[7:0], gen) : {16{16'hdead}};

  always @(negedge clk) begin
    blk_t e;
    if (!rst_n) begin
      outst      = 0;
      prev_stall = 1'b0;
      prev_val   = 1'b0;
    end else begin
      if (coe_rd_ena_o) begin
        rd_cnt++;
        outst++;
        check("addr_msb", coe_rd_addr_o[8], 1'b0);
      end
      if (prev_stall) begin
        check("stall_val", blk_val_o, 1'b1);
        check("stall_dat", blk_dat_o, held.dat);
        check("stall_sel", blk_sel_o, held.sel);
        check("stall_idx", blk_idx_o, held.idx);
        check("stall_last", blk_last_o, held.last);
      end
      if (blk_val_o) val_cnt++;
      if (blk_val_o && !prev_val) val_rise_cyc = cyc;
      if (blk_val_o && blk_rdy_i) begin
        check("sb_nonempty", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("blk_sel", blk_sel_o, e.sel);
          check("blk_idx", blk_idx_o, e.idx);
          check("blk_last", blk_last_o, e.last);
          check("blk_dat", blk_dat_o, e.dat);
        end
        outst--;
        blk_cnt++;
        last_acc_cyc = cyc;
      end
      if (coe_rd_ena_o || blk_val_o) check("outstanding_le2", outst <= 2, 1'b1);
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_val   = blk_val_o;
      prev_stall = blk_val_o && !blk_rdy_i;
      held       = '{sel: blk_sel_o, idx: blk_idx_o, last: blk_last_o, dat: blk_dat_o};
    end
  end

  task automatic add_comp(input logic [1:0] s, input int n, input bit is_last);
    for (int i = 0; i < n; i++)
      sb.push_back('{sel: s, idx: 8'(i), last: is_last && (i == n - 1), dat: mk_dat(s, 8'(i), gen)});
    exp_reads += n;
  endtask

  task automatic begin_cu(input logic [1:0] sz, input bit y, input bit u, input bit v);
    int nl = 4 << (2 * int'(sz));
    int nc = 1 << (2 * int'(sz));
    gen++;
    exp_reads = 0;
    rd_base   = rd_cnt;
    blk_base  = blk_cnt;
    val_base  = val_cnt;
    done_base = done_cnt;
    if (y) add_comp(2'd2, nl, !u && !v);
    if (u) add_comp(2'd1, nc, !v);
    if (v) add_comp(2'd0, nc, 1'b1);
    @(posedge clk); #1;
    cu_size_i = sz;
    cbf_y_i   = y;
    cbf_u_i   = u;
    cbf_v_i   = v;
    start_i   = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start_i   = 1'b0;
    cbf_y_i   = 1'b0;
    cbf_u_i   = 1'b0;
    cbf_v_i   = 1'b0;
    cu_size_i = 2'd0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == done_base; i++) @(posedge clk);
    check("done_seen", done_cnt != done_base, 1'b1);
    @(posedge clk); #1;
    check("idle_busy", busy_o, 1'b0);
  endtask

  task automatic end_cu();
    check("sb_drained", sb.size(), 0);
    check("read_count", rd_cnt - rd_base, exp_reads);
    check("block_count", blk_cnt - blk_base, exp_reads);
    check("done_pulses", done_cnt - done_base, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ena"}, coe_rd_ena_o, 1'b0);
    check({tag, "_addr"}, coe_rd_addr_o, 9'd0);
    check({tag, "_sel"}, coe_rd_sel_o, 2'd0);
    check({tag, "_val"}, blk_val_o, 1'b0);
    check({tag, "_dat"}, blk_dat_o, '0);
    check({tag, "_bsel"}, blk_sel_o, 2'd0);
    check({tag, "_idx"}, blk_idx_o, 8'd0);
    check({tag, "_last"}, blk_last_o, 1'b0);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_done"}, done_o, 1'b0);
  endtask

  initial begin
    bit hit;
    rst_n     = 1'b0;
    start_i   = 1'b0;
    cu_size_i = 2'd0;
    cbf_y_i   = 1'b0;
    cbf_u_i   = 1'b0;
    cbf_v_i   = 1'b0;
    blk_rdy_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Size 0, all components, consumer always ready.
    blk_rdy_i = 1'b1;
    begin_cu(2'd0, 1'b1, 1'b1, 1'b1);
    wait_done(100);
    end_cu();
    check("first_val_lat", val_rise_cyc - start_cyc, 3);
    check("back_to_back", last_acc_cyc - val_rise_cyc, 5);
    check("done_after_last", done_cyc - last_acc_cyc, 1);

    // Size 3, luma only: 256 blocks, index runs to 255.
    begin_cu(2'd3, 1'b1, 1'b0, 1'b0);
    wait_done(400);
    end_cu();
    check("done_after_last64", done_cyc - last_acc_cyc, 1);

    // Size 1 with a stalled then toggling consumer.
    blk_rdy_i = 1'b0;
    begin_cu(2'd1, 1'b1, 1'b1, 1'b1);
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("stall_reads", rd_cnt - rd_base, 2);
    check("stall_pops", blk_cnt - blk_base, 0);
    for (int i = 0; i < 200 && done_cnt == done_base; i++) begin
      blk_rdy_i = ~blk_rdy_i;
      @(posedge clk); #1;
    end
    blk_rdy_i = 1'b1;
    wait_done(50);
    end_cu();

    // No coded components.
    begin_cu(2'd2, 1'b0, 1'b0, 1'b0);
    wait_done(20);
    end_cu();
    check("zero_done_lat", done_cyc - start_cyc, 1);
    check("zero_val_never", val_cnt - val_base, 0);

    // Reset in the middle of luma of a 32x32 CU, then a fresh 8x8 CU.
    begin_cu(2'd2, 1'b1, 1'b1, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      hit = coe_rd_ena_o && coe_rd_sel_o == 2'd2 && coe_rd_addr_o == 9'd20;
    end
    check("reach_idx20", hit, 1'b1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    begin_cu(2'd0, 1'b1, 1'b1, 1'b1);
    wait_done(100);
    end_cu();

    // start_i during chroma reads must be ignored.
    begin_cu(2'd1, 1'b1, 1'b1, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      hit = coe_rd_ena_o && coe_rd_sel_o == 2'd1;
    end
    check("reach_rd_u", hit, 1'b1);
    start_i   = 1'b1;
    cu_size_i = 2'd3;
    cbf_v_i   = 1'b1;
    @(posedge clk); #1;
    start_i   = 1'b0;
    cu_size_i = 2'd0;
    cbf_v_i   = 1'b0;
    wait_done(200);
    end_cu();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
